// File: rtl/i281_pkg.sv
// Shared definitions for the i281 instruction-memory loader: state encoding,
// the NOP word and default geometry.
package i281_pkg;

  typedef enum logic [2:0] {
    CLEAR   = 3'd0,
    IDLE    = 3'd1,
    LOAD_HI = 3'd2,
    LOAD_LO = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int WORD_W_DEF = 16;
  localparam int BYTE_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;
  localparam int NOP_WORD   = 0;

endpackage

// File: rtl/user_code_ram.sv
// DEPTH x WORD_W storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; the owner clears them by writing.
module user_code_ram #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/user_code_mem.sv
// Loadable i281 instruction memory: clears itself after reset, then accepts a
// byte-streamed program (high byte first) while holding the CPU; fetch is a zero-latency read.
module user_code_mem
  import i281_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] PC_addr,
  output logic [WORD_W-1:0] Instr,
  output logic              Cpu_hold,
  input  logic              Load_start,
  input  logic              Load_end,
  input  logic [BYTE_W-1:0] Byte_in,
  input  logic              Byte_valid,
  output logic              Byte_ready,
  output logic              Load_done,
  output logic              Load_err,
  output logic [ADDR_W:0]   Word_count,
  output logic [BYTE_W-1:0] Load_sum
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, wr_ptr;
  logic [BYTE_W-1:0] hi_reg;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [WORD_W-1:0] ram_wdata, ram_rdata;
  logic              sess_clr, hi_take, lo_take, set_err;
  logic              word_last;

  assign word_last = (Word_count == (ADDR_W+1)'(DEPTH-1));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= CLEAR;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ram_we     = 1'b0;
    ram_waddr  = wr_ptr;
    ram_wdata  = {hi_reg, Byte_in};
    sess_clr   = 1'b0;
    hi_take    = 1'b0;
    lo_take    = 1'b0;
    set_err    = 1'b0;
    Byte_ready = 1'b0;
    Cpu_hold   = 1'b1;
    Load_done  = 1'b0;
    case (state)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_ptr;
        ram_wdata = '0;
        if (clr_ptr == ADDR_W'(DEPTH-1)) state_nxt = IDLE;
      end
      IDLE: begin
        Cpu_hold = 1'b0;
        if (Load_start) begin
          sess_clr  = 1'b1;
          state_nxt = LOAD_HI;
        end
      end
      LOAD_HI: begin
        Byte_ready = 1'b1;
        if (Load_start) begin
          sess_clr  = 1'b1;
          state_nxt = LOAD_HI;
        end else if (Load_end) begin
          state_nxt = DONE;
        end else if (Byte_valid) begin
          hi_take   = 1'b1;
          state_nxt = LOAD_LO;
        end
      end
      LOAD_LO: begin
        Byte_ready = 1'b1;
        // A restart discards the pending half word, even if its low byte arrives now.
        if (Load_start) begin
          sess_clr  = 1'b1;
          state_nxt = LOAD_HI;
        end else if (Byte_valid) begin
          lo_take   = 1'b1;
          ram_we    = 1'b1;
          state_nxt = (word_last || Load_end) ? DONE : LOAD_HI;
        end else if (Load_end) begin
          set_err   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        Load_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      clr_ptr    <= '0;
      wr_ptr     <= '0;
      hi_reg     <= '0;
      Word_count <= '0;
      Load_sum   <= '0;
      Load_err   <= 1'b0;
    end else begin
      if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
      if (sess_clr) begin
        wr_ptr     <= '0;
        Word_count <= '0;
        Load_sum   <= '0;
        Load_err   <= 1'b0;
      end
      if (hi_take) begin
        hi_reg   <= Byte_in;
        Load_sum <= Load_sum + Byte_in;
      end
      if (lo_take) begin
        wr_ptr     <= wr_ptr + 1'b1;
        Word_count <= Word_count + 1'b1;
        Load_sum   <= Load_sum + Byte_in;
      end
      if (set_err) Load_err <= 1'b1;
    end
  end

  user_code_ram #(
    .WORD_W(WORD_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (Clock),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(PC_addr),
    .rdata(ram_rdata)
  );

  assign Instr = Cpu_hold ? WORD_W'(NOP_WORD) : ram_rdata;

endmodule
